// File: rtl/ef_i2c_target.sv
// I2C target register file: 7-bit address match, NREGS x 8 regs, auto-increment pointer.
// Optional SCL/SDA majority glitch filter: define EF_I2C_TARGET_GLITCH_FILTER_EN.
module ef_i2c_target #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         NREGS       = 16,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_oen_o,
  output logic       wr_stb_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic       busy_o
);

  localparam int PW = $clog2(NREGS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RACK,
    S_IGNORE
  } state_t;

  state_t state, nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_sy, sda_sy;
  logic scl_s, sda_s;
  logic scl_q, sda_q;
  logic rise, fall, start_det, stop_det;

  logic [7:0]    regs [NREGS];
  logic [PW-1:0] ptr;
  logic [7:0]    sr;
  logic [3:0]    cnt;
  logic          phase;
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;
  logic          last_bit;

  logic cnt_clr, cnt_inc, shift_in;
  logic tx_load, tx_shift;
  logic ptr_load, ptr_inc, wr_en;
  logic phase_set, oen_nxt, busy_nxt;

  assign sda_o = 1'b0;

  // Synchronizers reset to the idle bus level so reset never fakes an edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
    end
  end

  assign scl_sy = scl_sync[SYNC_STAGES-1];
  assign sda_sy = sda_sync[SYNC_STAGES-1];

`ifdef EF_I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h, sda_h;
  logic       scl_m, sda_m;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_m <= 1'b1;
      sda_m <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_sy};
      sda_h <= {sda_h[0], sda_sy};
      scl_m <= (scl_sy & scl_h[0]) | (scl_sy & scl_h[1])
             | (scl_h[0] & scl_h[1]);
      sda_m <= (sda_sy & sda_h[0]) | (sda_sy & sda_h[1])
             | (sda_h[0] & sda_h[1]);
    end
  end

  assign scl_s = scl_m;
  assign sda_s = sda_m;
`else
  assign scl_s = scl_sy;
  assign sda_s = sda_sy;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  assign rise      = scl_s & ~scl_q;
  assign fall      = ~scl_s & scl_q;
  assign start_det = scl_s & scl_q & sda_q & ~sda_s;
  assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

  assign byte_in  = {sr[6:0], sda_s};
  assign rd_byte  = regs[ptr];
  assign last_bit = (cnt == 4'd7);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (start_det) begin
      nxt = S_ADDR;
    end else if (stop_det) begin
      nxt = S_IDLE;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (rise && last_bit)
            nxt = (byte_in[7:1] == ADDR) ? S_ADDR_ACK : S_IGNORE;
        end
        S_ADDR_ACK: begin
          if (fall && phase) nxt = sr[0] ? S_RDATA : S_PTR;
        end
        S_PTR: begin
          if (rise && last_bit) nxt = S_PTR_ACK;
        end
        S_PTR_ACK: begin
          if (fall && phase) nxt = S_WDATA;
        end
        S_WDATA: begin
          if (rise && last_bit) nxt = S_WDATA_ACK;
        end
        S_WDATA_ACK: begin
          if (fall && phase) nxt = S_WDATA;
        end
        S_RDATA: begin
          if (rise && last_bit) nxt = S_RACK;
        end
        S_RACK: begin
          if (rise && sda_s)       nxt = S_IGNORE;
          else if (fall && phase)  nxt = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  // phase marks the second SCL fall of an ACK slot (end of the 9th clock).
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    shift_in  = 1'b0;
    tx_load   = 1'b0;
    tx_shift  = 1'b0;
    ptr_load  = 1'b0;
    ptr_inc   = 1'b0;
    wr_en     = 1'b0;
    phase_set = 1'b0;
    oen_nxt   = sda_oen_o;
    busy_nxt  = busy_o;
    if (start_det || stop_det) begin
      cnt_clr  = 1'b1;
      oen_nxt  = 1'b1;
      busy_nxt = 1'b0;
    end else begin
      unique case (state)
        S_ADDR: begin
          if (rise) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
          end
        end
        S_PTR: begin
          if (rise) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
            ptr_load = last_bit;
          end
        end
        S_WDATA: begin
          if (rise) begin
            shift_in = 1'b1;
            cnt_inc  = 1'b1;
            wr_en    = last_bit;
            ptr_inc  = last_bit;
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (fall && !phase) begin
            phase_set = 1'b1;
            oen_nxt   = 1'b0;
            busy_nxt  = 1'b1;
          end else if (fall) begin
            cnt_clr = 1'b1;
            oen_nxt = 1'b1;
            if (state == S_ADDR_ACK && sr[0]) begin
              tx_load = 1'b1;
              oen_nxt = rd_byte[7];
            end
          end
        end
        S_RDATA: begin
          if (rise) cnt_inc = 1'b1;
          if (fall) begin
            tx_shift = 1'b1;
            oen_nxt  = sr[7];
          end
        end
        S_RACK: begin
          if (rise) ptr_inc = 1'b1;
          if (fall && !phase) begin
            phase_set = 1'b1;
            oen_nxt   = 1'b1;
          end else if (fall) begin
            cnt_clr = 1'b1;
            tx_load = 1'b1;
            oen_nxt = rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      sr        <= '0;
      phase     <= 1'b0;
      ptr       <= '0;
      sda_oen_o <= 1'b1;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      wr_stb_o  <= wr_en;
      sda_oen_o <= oen_nxt;
      busy_o    <= busy_nxt;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 4'd1;
      if (shift_in)      sr <= byte_in;
      else if (tx_load)  sr <= {rd_byte[6:0], 1'b1};
      else if (tx_shift) sr <= {sr[6:0], 1'b1};
      if (nxt != state)   phase <= 1'b0;
      else if (phase_set) phase <= 1'b1;
      if (ptr_load)     ptr <= byte_in[PW-1:0];
      else if (ptr_inc) ptr <= ptr + PW'(1);
      if (wr_en) begin
        wr_addr_o <= 8'(ptr);
        wr_data_o <= byte_in;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[ptr] <= byte_in;
    end
  end

endmodule

// File: doc/ef_i2c_target.md
# ef_i2c_target

I2C target (slave) register device that sits directly downstream of the EF_I2C master on the shared open-drain `scl`/`sda` pins. It is the device the master's transactions address and read back. It samples SCL/SDA with the system clock, decodes START/STOP, matches a fixed 7-bit address, and serves an NREGS×8 register file with an auto-incrementing pointer. It drives SDA only, via an active-low output enable, and never stretches SCL.

## Interface
- `ADDR`, 7'h50, 7-bit target address.
- `NREGS`, 16, register count; power of two, 2..256.
- `SYNC_STAGES`, 2, input synchronizer depth (≥2).
- `clk_i`  in  1  system clock; frequency ≥ 10× SCL.
- `rst_i`  in  1  reset; synchronous, active-high.
- `scl_i`  in  1  SCL pin level.
- `sda_i`  in  1  SDA pin level.
- `sda_o`  out  1  SDA output value; constant 0.
- `sda_oen_o`  out  1  SDA output enable, active-low; 0 pulls the pin low.
- `wr_stb_o`  out  1  one-cycle pulse per register byte written.
- `wr_addr_o`  out  8  register index of that write, zero-extended.
- `wr_data_o`  out  8  byte written.
- `busy_o`  out  1  high from own-address ACK to STOP or repeated START.

## Operation
- Inputs pass through SYNC_STAGES flops, then one history flop. Edges are derived from the synchronized value vs. the history flop.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are legal in any state and take priority over bit handling on the same cycle.
- Bits are sampled on a synchronized SCL rise and shifted in MSB first. SDA output changes only on the cycle after a synchronized SCL fall.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- IDLE→ADDR on START; any state→ADDR on repeated START; any state→IDLE on STOP.
- ADDR: after 8 bits, compare [7:1] with ADDR.
  - Match: go to ADDR_ACK; drive ACK (oen=0) for the 9th clock; assert busy.
  - Mismatch: go to IGNORE with SDA released.
- After ADDR_ACK: R/W=0 goes to PTR; R/W=1 goes to RDATA.
- PTR: 8 bits, then ptr = byte mod NREGS, ACK, then WDATA.
- WDATA: 8 bits, then reg[ptr] is written, wr_stb_o pulses, ACK, ptr increments. Bytes continue until STOP or START.
- RDATA: shift reg[ptr] out MSB first. A bit of 0 drives oen=0; a bit of 1 releases. At the 9th SCL rise, ptr increments and the master's ACK is sampled.
  - SDA=0 (ACK): next byte.
  - SDA=1 (NACK): IGNORE.
- Pointer arithmetic is (ptr+1) mod NREGS and wraps from NREGS-1 to 0.
- IGNORE: SDA released; leaves only on STOP or START.
- Reset values:
  - Outputs: sda_oen_o=1, sda_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, busy_o=0.
  - Internal: ptr=0, all registers 0, state IDLE.
- Reset mid-transfer releases SDA at the next clk_i edge. The bus is then ignored until a START.

## Timing
- Pin-to-detect latency is SYNC_STAGES+1 cycles (+2 with the filter below).
- ACK drive: oen=0 on the cycle after the synchronized SCL fall that ends bit 8. Release on the cycle after the synchronized SCL fall that ends bit 9.
- Read data: bit 7 is driven on the cycle after the SCL fall ending the address/data ACK. Each following bit is driven on the cycle after each SCL fall.
- wr_stb_o is asserted on the cycle after the 8th data-bit SCL rise, together with wr_addr_o/wr_data_o. Those outputs hold until the next write.
- busy_o rises with the ACK drive and falls the cycle after STOP/START detection.

## Configuration
- `EF_I2C_TARGET_GLITCH_FILTER_EN` defined: each synchronized input passes a 3-sample majority filter before edge detection. This adds 2 cycles of latency and rejects pulses ≤1 clk_i wide.
- Undefined: no filter; a 1-cycle glitch on SCL while SDA changes may be decoded as an edge.

## Test plan
- Write 0x50/W, ptr 0x03, data 0xA5, 0x3C, STOP → ACK on all 4 bytes; reg[3]=0xA5, reg[4]=0x3C; two wr_stb_o pulses with addr 3/4.
- Write ptr 0x0F, data 0x11, 0x22 (NREGS=16) → reg[15]=0x11, reg[0]=0x22 (wrap).
- Write ptr 0x03, repeated START, 0x50/R, read 2 bytes with ACK then NACK, STOP → 0xA5, 0x3C on SDA; ptr ends at 5.
- Address 0x51/W then 0x77 → NACK on address; sda_oen_o stays 1 through STOP; no wr_stb_o; busy_o=0.
- rst_i asserted during read bit 3 while the target drives 0 → sda_oen_o=1 next cycle; all registers read 0 after the next START and pointer write of 0.
- With filter enabled: inject a 1-cycle SCL low pulse mid-bit → no extra bit shifted; byte decodes correctly.
